// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared constants and types for the VeriRISC instruction sequencer
//
// Purpose: opcode and phase encodings, default field widths, ALU-class opcode helper.
// Ports:   none (package).
package cpu_pkg;

    localparam int OPCODE_WIDTH_DEF = 3;
    localparam int PHASE_WIDTH_DEF  = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read a memory operand and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control interface between instruction register, sequencer and datapath
//
// Purpose: bundles the sequencer inputs (en, opcode, zero) and its decoded strobes.
// Modports: master - drives en/opcode/zero, observes phase and strobes (IR/datapath side).
//           slave  - the sequencer itself.
interface cpu_sequencer_if
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF
);
    logic                    en;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic [PHASE_WIDTH-1:0]  phase;
    logic                    sel;
    logic                    rd;
    logic                    ld_ir;
    logic                    inc_pc;
    logic                    halt;
    logic                    ld_pc;
    logic                    data_e;
    logic                    ld_ac;
    logic                    wr;

    modport master (
        output en, opcode, zero,
        input  phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

    modport slave (
        input  en, opcode, zero,
        output phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

endinterface

// File: rtl/cpu_sequencer_phase_counter.sv
// rtl/cpu_sequencer_phase_counter.sv - wrapping phase counter with count enable
//
// Purpose: WIDTH-bit up counter, wraps from all-ones to zero.
// Ports:   clk     - clock, rising edge
//          rst     - synchronous active-high reset to zero
//          i_en    - count enable; low holds the count
//          o_count - current count
module phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Natural binary overflow provides the 7 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase VeriRISC instruction sequencer and control decode
//
// Purpose: steps the phase counter through fetch/execute, tracks the halted state and
//          decodes every datapath strobe from (phase, halted, opcode, zero).
// Ports:   clk - clock, rising edge
//          rst - synchronous active-high reset
//          bus - slave side of cpu_sequencer_if: en, opcode, zero in;
//                phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr out
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cpu_sequencer_if.slave bus
);

    logic                    r_halted;
    logic [PHASE_WIDTH-1:0]  w_phase;
    logic [OPCODE_WIDTH-1:0] w_opcode_raw;
    opcode_t                 w_opcode;
    logic                    w_alu;
    logic                    w_halt_entry;
    logic                    w_cnt_en;

    logic w_sel, w_rd, w_ld_ir, w_inc_pc, w_halt, w_ld_pc, w_data_e, w_ld_ac, w_wr;

    assign w_opcode_raw = bus.opcode;
    assign w_opcode     = opcode_t'(w_opcode_raw);
    assign w_alu        = is_aluop(w_opcode);

    assign w_halt_entry = bus.en && !r_halted
                          && (w_phase == PH_OP_ADDR) && (w_opcode == OP_HLT);

    // The entry edge must also hold the counter so the halted state parks at phase 4.
    assign w_cnt_en = bus.en && !r_halted && !w_halt_entry;

    phase_counter #(
        .WIDTH (PHASE_WIDTH)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .o_count (w_phase)
    );

    // Halted is sticky; only reset clears it, and reset wins over entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_entry) begin
            r_halted <= 1'b1;
        end
    end

    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_inc_pc = 1'b0;
        w_halt   = 1'b0;
        w_ld_pc  = 1'b0;
        w_data_e = 1'b0;
        w_ld_ac  = 1'b0;
        w_wr     = 1'b0;

        if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (phase_t'(w_phase))
                PH_INST_ADDR: begin
                    w_sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    w_halt   = (w_opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    w_rd = w_alu;
                end
                PH_ALU_OP: begin
                    w_rd     = w_alu;
                    w_inc_pc = (w_opcode == OP_SKZ) && bus.zero;
                    w_ld_pc  = (w_opcode == OP_JMP);
                    w_data_e = (w_opcode == OP_STO);
                end
                PH_STORE: begin
                    w_rd     = w_alu;
                    w_ld_ac  = w_alu;
                    w_ld_pc  = (w_opcode == OP_JMP);
                    w_wr     = (w_opcode == OP_STO);
                    w_data_e = (w_opcode == OP_STO);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.phase  = w_phase;
    assign bus.sel    = w_sel;
    assign bus.rd     = w_rd;
    assign bus.ld_ir  = w_ld_ir;
    assign bus.inc_pc = w_inc_pc;
    assign bus.halt   = w_halt;
    assign bus.ld_pc  = w_ld_pc;
    assign bus.data_e = w_data_e;
    assign bus.ld_ac  = w_ld_ac;
    assign bus.wr     = w_wr;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_sequencer_if #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) bus ();

    cpu_sequencer #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    logic [8:0] w_strobes;
    assign w_strobes = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
                        bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};

    localparam logic [8:0] S_RESET = 9'b100000000;
    localparam logic [8:0] S_HALTD = 9'b000010000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1 time unit later, sampling 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Runs one full instruction from phase 0, checking phase and strobes in every phase.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [0:7][8:0] exp);
        bus.opcode = op;
        bus.zero   = z;
        bus.en     = 1'b1;
        for (int p = 0; p < 8; p++) begin
            settle();
            check($sformatf("%s phase p%0d", name, p), 32'(bus.phase), 32'(p));
            check($sformatf("%s strobes p%0d", name, p), 32'(w_strobes), 32'(exp[p]));
            tick();
        end
        settle();
        check($sformatf("%s wrap", name), 32'(bus.phase), 32'd0);
    endtask

    localparam logic [8:0] F0 = 9'b100000000;
    localparam logic [8:0] F1 = 9'b110000000;
    localparam logic [8:0] F2 = 9'b111000000;
    localparam logic [8:0] F3 = 9'b111000000;
    localparam logic [8:0] F4 = 9'b000100000;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        settle();
        check("reset phase", 32'(bus.phase), 32'd0);
        check("reset strobes", 32'(w_strobes), 32'(S_RESET));
        rst = 1'b0;

        run_instr("ADD", 3'd2, 1'b0, {F0, F1, F2, F3, F4, 9'b010000000, 9'b010000000, 9'b010000010});
        run_instr("STO", 3'd6, 1'b1, {F0, F1, F2, F3, F4, 9'b000000000, 9'b000000100, 9'b000000101});
        run_instr("SKZ1", 3'd1, 1'b1, {F0, F1, F2, F3, F4, 9'b000000000, 9'b000100000, 9'b000000000});
        run_instr("SKZ0", 3'd1, 1'b0, {F0, F1, F2, F3, F4, 9'b000000000, 9'b000000000, 9'b000000000});
        run_instr("JMP", 3'd7, 1'b0, {F0, F1, F2, F3, F4, 9'b000000000, 9'b000001000, 9'b000001000});

        // Enable gating in phase 5, then reset from phase 6.
        bus.opcode = 3'd2;
        bus.en     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        settle();
        check("gate pre phase", 32'(bus.phase), 32'd5);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check($sformatf("gate hold phase c%0d", i), 32'(bus.phase), 32'd5);
            check($sformatf("gate hold strobes c%0d", i), 32'(w_strobes), 32'(9'b010000000));
        end
        bus.en = 1'b1;
        tick();
        settle();
        check("gate resume phase", 32'(bus.phase), 32'd6);
        rst = 1'b1;
        tick();
        settle();
        check("rst from p6 phase", 32'(bus.phase), 32'd0);
        check("rst from p6 strobes", 32'(w_strobes), 32'(S_RESET));
        rst = 1'b0;

        // HLT: one increment in phase 4, then parked until reset.
        bus.opcode = 3'd0;
        bus.en     = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        settle();
        check("hlt p4 phase", 32'(bus.phase), 32'd4);
        check("hlt p4 strobes", 32'(w_strobes), 32'(9'b000110000));
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.en   = i[0];
            bus.zero = i[1];
            settle();
            check($sformatf("halted phase c%0d", i), 32'(bus.phase), 32'd4);
            check($sformatf("halted strobes c%0d", i), 32'(w_strobes), 32'(S_HALTD));
        end
        rst = 1'b1;
        tick();
        settle();
        check("hlt reset phase", 32'(bus.phase), 32'd0);
        check("hlt reset halt", 32'(bus.halt), 32'd0);
        check("hlt reset strobes", 32'(w_strobes), 32'(S_RESET));
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
